mem_port_arbiter3: RTL and testbench

- Arbitrates one shared memory/bus port among three requesters: 0 = instruction fetch, 1 = load/store unit, 2 = external/debug master.
- Produces the 2-bit select that drives the core's 3:1 switch mux (encoding 00/01/10) on the shared address/data path.
- Sequences each transaction through a valid/ready handshake and aborts hung transactions with a watchdog.

---
 rtl/mem_port_arbiter3_pkg.sv | 37 +++
 rtl/mem_port_arbiter3_arb_pick3.sv | 53 +++++
 rtl/mem_port_arbiter3.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter3.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter3_pkg.sv
// mem_port_arbiter3_pkg
// Shared encodings and helpers for the three-way memory port arbiter:
//   - select encodings for the core's 3:1 switch mux (11 is never driven)
//   - FSM state encoding (IDLE / BUSY)
//   - sel_onehot : select code -> one-hot requester vector
//   - sel_next   : modulo-3 successor of a select code (round-robin scan)
package mem_port_arbiter3_pkg;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    function automatic logic [2:0] sel_onehot(input logic [1:0] s);
        case (s)
            SEL_REQ0: return 3'b001;
            SEL_REQ1: return 3'b010;
            SEL_REQ2: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    // 11 maps to 00 so a corrupted pointer still lands on a legal requester.
    function automatic logic [1:0] sel_next(input logic [1:0] s);
        case (s)
            SEL_REQ0: return SEL_REQ1;
            SEL_REQ1: return SEL_REQ2;
            default:  return SEL_REQ0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter3_arb_pick3.sv
// arb_pick3
// Combinational winner selection among three requesters.
// Ports:
//   req        in  3  raw request vector
//   mask       in  3  requesters excluded from this pick (finishing owner)
//   last_grant in  2  previous winner; round-robin scan starts after it
//   rr_en      in  1  1 = round-robin, 0 = fixed priority 0 > 1 > 2
//   any        out 1  at least one unmasked request present
//   winner     out 2  select code of the chosen requester (00 when none)
module arb_pick3
    import mem_port_arbiter3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] mask,
    input  logic [1:0] last_grant,
    input  logic       rr_en,
    output logic       any,
    output logic [1:0] winner
);

    logic [2:0] cand;
    logic [1:0] scan0;
    logic [1:0] scan1;
    logic [1:0] scan2;

    assign cand  = req & ~mask;
    assign any   = |cand;
    assign scan0 = sel_next(last_grant);
    assign scan1 = sel_next(scan0);
    assign scan2 = sel_next(scan1);

    always_comb begin
        winner = SEL_REQ0;
        if (rr_en) begin
            if (|(cand & sel_onehot(scan0))) begin
                winner = scan0;
            end else if (|(cand & sel_onehot(scan1))) begin
                winner = scan1;
            end else if (|(cand & sel_onehot(scan2))) begin
                winner = scan2;
            end
        end else begin
            if (cand[0]) begin
                winner = SEL_REQ0;
            end else if (cand[1]) begin
                winner = SEL_REQ1;
            end else if (cand[2]) begin
                winner = SEL_REQ2;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter3.sv
// mem_port_arbiter3
// Arbitrates one shared memory/bus port among instruction fetch (0),
// load/store unit (1) and external/debug master (2). The registered select
// drives the core's 3:1 switch mux; each grant runs a valid/ready
// transaction guarded by a watchdog.
// Ports:
//   clk        in  1  core clock, rising edge
//   rst_n      in  1  synchronous active-low reset
//   req        in  3  per-requester request, held until ack/err
//   ack        out 3  one-hot completion pulse (combinational on mem_ready)
//   err        out 3  one-hot watchdog abort pulse
//   sel        out 2  mux select 00/01/10
//   mem_valid  out 1  shared-port request valid
//   mem_ready  in  1  shared-port completion
//   busy       out 1  high while a transaction is in flight
module mem_port_arbiter3
    import mem_port_arbiter3_pkg::*;
#(
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] ack,
    output logic [2:0] err,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ready,
    output logic       busy
);

    localparam bit WDOG_EN = (TIMEOUT > 0);
    // Count value seen during the TIMEOUT-th BUSY cycle (count starts at 0).
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic RR_ON = (RR_EN != 0);

    arb_state_e       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_busy;
    logic [2:0] pick_mask;
    logic       pick_any;
    logic [1:0] pick_win;

    assign is_busy   = (state_q == ARB_BUSY);
    assign mem_valid = is_busy;
    assign busy      = is_busy;
    assign sel       = sel_q;

    // The finishing owner is masked so a back-to-back grant goes elsewhere;
    // in IDLE nothing is masked.
    assign pick_mask = is_busy ? sel_onehot(sel_q) : 3'b000;

    arb_pick3 u_pick (
        .req        (req),
        .mask       (pick_mask),
        .last_grant (last_q),
        .rr_en      (RR_ON),
        .any        (pick_any),
        .winner     (pick_win)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack     = 3'b000;
        err     = 3'b000;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    sel_d   = pick_win;
                    last_d  = pick_win;
                end
            end
            ARB_BUSY: begin
                // Completion takes precedence over a same-cycle expiry.
                if (mem_ready) begin
                    ack   = sel_onehot(sel_q);
                    cnt_d = '0;
                    if (pick_any) begin
                        sel_d  = pick_win;
                        last_d = pick_win;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    err     = sel_onehot(sel_q);
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            sel_q   <= SEL_REQ0;
            last_q  <= SEL_REQ2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    a_sel_legal: assert property (@(posedge clk) disable iff (!rst_n) sel_q != SEL_NONE);

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Testbench for mem_port_arbiter3. Four instances:
//   0: RR_EN=1 TIMEOUT=4   1: RR_EN=0 TIMEOUT=4
//   2: defaults (RR_EN=1 TIMEOUT=16)   3: RR_EN=1 TIMEOUT=0
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mem_port_arbiter3;

    typedef struct packed {
        logic       rst_n;
        logic [2:0] req;
        logic       rdy;
        logic [2:0] ack;
        logic [2:0] err;
        logic [1:0] sel;
        logic       mv;
        logic       busy;
    } vec_t;

    logic       clk;
    logic [3:0] rst_n_v;
    logic [2:0] req_v  [4];
    logic [3:0] rdy_v;
    logic [2:0] ack_v  [4];
    logic [2:0] err_v  [4];
    logic [1:0] sel_v  [4];
    logic [3:0] mv_v;
    logic [3:0] busy_v;

    int tests;
    int fails;

    vec_t rr_q[$];
    vec_t fp_q[$];

    mem_port_arbiter3 #(.RR_EN(1), .TIMEOUT(4), .CNT_W(5)) dut_rr (
        .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .ack(ack_v[0]), .err(err_v[0]),
        .sel(sel_v[0]), .mem_valid(mv_v[0]), .mem_ready(rdy_v[0]), .busy(busy_v[0])
    );
    mem_port_arbiter3 #(.RR_EN(0), .TIMEOUT(4), .CNT_W(5)) dut_fp (
        .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .ack(ack_v[1]), .err(err_v[1]),
        .sel(sel_v[1]), .mem_valid(mv_v[1]), .mem_ready(rdy_v[1]), .busy(busy_v[1])
    );
    mem_port_arbiter3 dut_df (
        .clk(clk), .rst_n(rst_n_v[2]), .req(req_v[2]), .ack(ack_v[2]), .err(err_v[2]),
        .sel(sel_v[2]), .mem_valid(mv_v[2]), .mem_ready(rdy_v[2]), .busy(busy_v[2])
    );
    mem_port_arbiter3 #(.RR_EN(1), .TIMEOUT(0), .CNT_W(5)) dut_nw (
        .clk(clk), .rst_n(rst_n_v[3]), .req(req_v[3]), .ack(ack_v[3]), .err(err_v[3]),
        .sel(sel_v[3]), .mem_valid(mv_v[3]), .mem_ready(rdy_v[3]), .busy(busy_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packed compare order: {ack, err, sel, mem_valid, busy}
    task automatic run_row(input int d, input vec_t v, input string tag, input int idx);
        @(negedge clk);
        rst_n_v[d] = v.rst_n;
        req_v[d]   = v.req;
        rdy_v[d]   = v.rdy;
        #1;
        chk($sformatf("%s[%0d] {ack,err,sel,mv,busy}", tag, idx),
            32'({ack_v[d], err_v[d], sel_v[d], mv_v[d], busy_v[d]}),
            32'({v.ack, v.err, v.sel, v.mv, v.busy}));
    endtask

    task automatic drive(input int d, input logic r, input logic [2:0] q, input logic y);
        @(negedge clk);
        rst_n_v[d] = r;
        req_v[d]   = q;
        rdy_v[d]   = y;
        #1;
    endtask

    initial begin
        int  mvc;
        int  errc;
        int  ackc;
        bit  seen;
        logic [2:0] err_seen;

        tests = 0;
        fails = 0;
        rst_n_v = 4'b0000;
        rdy_v   = 4'b0000;
        for (int i = 0; i < 4; i++) req_v[i] = 3'b000;

        //                   rst   req    rdy   ack     err     sel    mv    busy
        // reset
        rr_q.push_back(vec_t'({1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        // single request from requester 1, ready on the third valid cycle
        rr_q.push_back(vec_t'({1'b1, 3'b010, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b1, 3'b010, 1'b0, 3'b000, 3'b000, 2'b01, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b010, 1'b0, 3'b000, 3'b000, 2'b01, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b010, 1'b1, 3'b010, 3'b000, 2'b01, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0}));
        // spurious ready while idle
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b1, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b1, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b1, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0}));
        // watchdog abort on 4th valid cycle
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b100, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b10, 1'b0, 1'b0}));
        // ready on the 4th valid cycle: completion beats expiry
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b1, 3'b100, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b10, 1'b0, 1'b0}));
        // reset during BUSY with sel = 10
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b1, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b0, 3'b100, 1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b1}));
        // released with req = 111, ready tied high: round-robin 00,01,10,00,01
        rr_q.push_back(vec_t'({1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        rr_q.push_back(vec_t'({1'b1, 3'b111, 1'b1, 3'b001, 3'b000, 2'b00, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b111, 1'b1, 3'b010, 3'b000, 2'b01, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b111, 1'b1, 3'b100, 3'b000, 2'b10, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b111, 1'b1, 3'b001, 3'b000, 2'b00, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b1, 3'b010, 3'b000, 2'b01, 1'b1, 1'b1}));
        rr_q.push_back(vec_t'({1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0}));

        // fixed priority with masking
        fp_q.push_back(vec_t'({1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        fp_q.push_back(vec_t'({1'b1, 3'b011, 1'b1, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        fp_q.push_back(vec_t'({1'b1, 3'b011, 1'b1, 3'b001, 3'b000, 2'b00, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b011, 1'b1, 3'b010, 3'b000, 2'b01, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b011, 1'b1, 3'b001, 3'b000, 2'b00, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b001, 1'b1, 3'b010, 3'b000, 2'b01, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b001, 1'b1, 3'b001, 3'b000, 2'b00, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b001, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        fp_q.push_back(vec_t'({1'b1, 3'b001, 1'b1, 3'b001, 3'b000, 2'b00, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        fp_q.push_back(vec_t'({1'b1, 3'b110, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0}));
        fp_q.push_back(vec_t'({1'b1, 3'b110, 1'b1, 3'b010, 3'b000, 2'b01, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b110, 1'b1, 3'b100, 3'b000, 2'b10, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b000, 1'b1, 3'b010, 3'b000, 2'b01, 1'b1, 1'b1}));
        fp_q.push_back(vec_t'({1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0}));

        for (int i = 0; i < rr_q.size(); i++) run_row(0, rr_q[i], "rr", i);
        for (int i = 0; i < fp_q.size(); i++) run_row(1, fp_q[i], "fp", i);

        // Default watchdog: err on exactly the 16th valid cycle, no ack.
        drive(2, 1'b0, 3'b000, 1'b0);
        drive(2, 1'b0, 3'b000, 1'b0);
        mvc = 0; ackc = 0; seen = 1'b0; err_seen = 3'b000;
        for (int c = 0; c < 40 && !seen; c++) begin
            drive(2, 1'b1, 3'b001, 1'b0);
            if (mv_v[2]) mvc++;
            if (ack_v[2] != 3'b000) ackc++;
            if (err_v[2] != 3'b000) begin
                seen = 1'b1;
                err_seen = err_v[2];
            end
        end
        chk("df watchdog err seen", 32'(seen), 32'd1);
        chk("df watchdog err value", 32'(err_seen), 32'h1);
        chk("df valid cycles to err", 32'(mvc), 32'd16);
        chk("df ack during timeout", 32'(ackc), 32'd0);
        drive(2, 1'b1, 3'b000, 1'b0);
        chk("df valid after err", 32'({mv_v[2], busy_v[2]}), 32'd0);

        // Watchdog disabled: 40 valid cycles without ready never abort.
        drive(3, 1'b0, 3'b000, 1'b0);
        mvc = 0; errc = 0;
        for (int c = 0; c < 41; c++) begin
            drive(3, 1'b1, 3'b001, 1'b0);
            if (mv_v[3]) mvc++;
            if (err_v[3] != 3'b000) errc++;
        end
        chk("nw valid cycles", 32'(mvc), 32'd40);
        chk("nw err count", 32'(errc), 32'd0);
        drive(3, 1'b1, 3'b001, 1'b1);
        chk("nw late ack", 32'({ack_v[3], mv_v[3]}), 32'({3'b001, 1'b1}));
        drive(3, 1'b1, 3'b000, 1'b0);
        chk("nw idle after ack", 32'({mv_v[3], busy_v[3]}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
